// File: rtl/signal_measure_pkg.sv
// Shared types and constants for the signal period/duty measurement block.
package signal_measure_pkg;

  localparam int unsigned CNT_W    = 20;
  localparam int unsigned FREQ_W   = 26;
  localparam int unsigned DUTY_W   = 8;
  localparam int unsigned TIMEOUT  = (1 << 20) - 1;
  localparam int unsigned DIV_W    = 32;
  localparam int unsigned DUTY_MAX = 100;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW,
    CALC_FREQ,
    CALC_DUTY,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses one
// cycle after the last step with quotient/remainder stable until next start.
module seq_divider
  import signal_measure_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  localparam int unsigned STEP_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0]  quo_q;
  logic [DIV_W-1:0]  den_q;
  logic [DIV_W-1:0]  rem_q;
  logic [STEP_W-1:0] step_cnt;
  logic              active;
  logic [DIV_W:0]    shifted;
  logic [DIV_W:0]    trial;

  // The partial remainder is always below the divisor, so one extra bit
  // is enough to hold the shifted value and the sign of the trial subtract.
  always_comb begin
    shifted = {rem_q, quo_q[DIV_W-1]};
    trial   = shifted - {1'b0, den_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      step_cnt <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo_q    <= dividend;
        den_q    <= divisor;
        rem_q    <= '0;
        step_cnt <= STEP_W'(DIV_W);
        active   <= 1'b1;
      end else if (active) begin
        if (!trial[DIV_W]) begin
          rem_q <= trial[DIV_W-1:0];
          quo_q <= {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DIV_W-1:0];
          quo_q <= {quo_q[DIV_W-2:0], 1'b0};
        end
        step_cnt <= step_cnt - STEP_W'(1);
        if (step_cnt == STEP_W'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/signal_measure_ctrl.sv
// Measures one high+low period of sig_in in clk cycles, then derives
// frequency and duty cycle with a single time-shared sequential divider.
module signal_measure_ctrl
  import signal_measure_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sig_in,
  output logic              busy,
  output logic              finish,
  output logic [FREQ_W-1:0] freq,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  low_time
);

  state_t state, state_next;

  logic              sync1, sync2, sig_prev;
  logic              rise, fall;
  logic [CNT_W-1:0]  high_cnt, low_cnt, stay_cnt;
  logic [CNT_W:0]    period;
  logic              measuring, timed_out;
  logic              div_start, div_done;
  logic [DIV_W-1:0]  div_dividend, div_divisor, div_quot, div_rem_unused;
  logic [FREQ_W-1:0] freq_res;
  logic [DUTY_W-1:0] duty_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sync1    <= sig_in;
      sync2    <= sync1;
      sig_prev <= sync2;
    end
  end

  assign rise      = sync2 & ~sig_prev;
  assign fall      = ~sync2 & sig_prev;
  assign period    = {1'b0, high_cnt} + {1'b0, low_cnt};
  assign measuring = (state == WAIT_RISE) || (state == MEAS_HIGH) || (state == MEAS_LOW);
  assign timed_out = measuring && (stay_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    div_start    = 1'b0;
    div_dividend = DIV_W'(CLK_FREQ);
    div_divisor  = DIV_W'(period);
    case (state)
      IDLE:      if (enable) state_next = WAIT_RISE;
      WAIT_RISE: if (timed_out) state_next = DONE;
                 else if (rise) state_next = MEAS_HIGH;
      MEAS_HIGH: if (timed_out) state_next = DONE;
                 else if (fall) state_next = MEAS_LOW;
      MEAS_LOW: begin
        if (timed_out) state_next = DONE;
        else if (rise) begin
          state_next = CALC_FREQ;
          div_start  = 1'b1;
        end
      end
      CALC_FREQ: begin
        div_dividend = DIV_W'(high_cnt) * DIV_W'(DUTY_MAX);
        if (div_done) begin
          state_next = CALC_DUTY;
          div_start  = 1'b1;
        end
      end
      CALC_DUTY: if (div_done) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The completing rise is not counted, so high+low is exactly one period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stay_cnt <= '0;
      high_cnt <= '0;
      low_cnt  <= '0;
      freq_res <= '0;
      duty_res <= '0;
    end else begin
      if (state_next != state) stay_cnt <= '0;
      else                     stay_cnt <= stay_cnt + CNT_W'(1);
      case (state)
        WAIT_RISE: if (rise) high_cnt <= CNT_W'(1);
        MEAS_HIGH: begin
          if (fall) low_cnt  <= CNT_W'(1);
          else      high_cnt <= high_cnt + CNT_W'(1);
        end
        MEAS_LOW:  if (!rise) low_cnt <= low_cnt + CNT_W'(1);
        CALC_FREQ: if (div_done)
          freq_res <= (|div_quot[DIV_W-1:FREQ_W]) ? '1 : div_quot[FREQ_W-1:0];
        CALC_DUTY: if (div_done)
          duty_res <= (div_quot > DIV_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX)
                                                    : div_quot[DUTY_W-1:0];
        default: ;
      endcase
      // A timeout reports an all-zero result through the normal DONE path.
      if (timed_out) begin
        high_cnt <= '0;
        low_cnt  <= '0;
        freq_res <= '0;
        duty_res <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      finish    <= 1'b0;
      freq      <= '0;
      duty      <= '0;
      high_time <= '0;
      low_time  <= '0;
    end else begin
      finish <= 1'b0;
      if (state == IDLE && enable) busy <= 1'b1;
      if (state == DONE) begin
        busy      <= 1'b0;
        finish    <= 1'b1;
        freq      <= freq_res;
        duty      <= duty_res;
        high_time <= high_cnt;
        low_time  <= low_cnt;
      end
    end
  end

  seq_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem_unused)
  );

endmodule

// File: tb/tb_signal_measure_ctrl.sv
// Directed bench for signal_measure_ctrl: arithmetic reference model of the
// reported results plus an every-cycle output compare.
module tb_signal_measure_ctrl;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int          T_OUT    = 500;
  localparam int          LAT_MAX  = 2 * 32 + 4 + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic        busy, finish;
  logic [25:0] freq;
  logic [7:0]  duty;
  logic [19:0] high_time, low_time;

  int n_cmp = 0;
  int n_bad = 0;
  int finish_count = 0;

  int  pend_freq, pend_duty, pend_high, pend_low;
  bit  pend_valid = 1'b0;
  int  exp_freq = 0, exp_duty = 0, exp_high = 0, exp_low = 0;

  signal_measure_ctrl #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_CYC(T_OUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sig_in    (sig_in),
    .busy      (busy),
    .finish    (finish),
    .freq      (freq),
    .duty      (duty),
    .high_time (high_time),
    .low_time  (low_time)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Results follow directly from the high/low lengths driven onto sig_in.
  task automatic model(input int h, input int l);
    longint p, f, d;
    p = h + l;
    f = CLK_FREQ / p;
    if (f > 64'd67108863) f = 67108863;
    d = (h * 100) / p;
    if (d > 100) d = 100;
    pend_freq  = int'(f);
    pend_duty  = int'(d);
    pend_high  = h;
    pend_low   = l;
    pend_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_freq = 0; exp_duty = 0; exp_high = 0; exp_low = 0;
      pend_valid = 1'b0;
    end else if (finish) begin
      finish_count++;
      if (pend_valid) begin
        exp_freq = pend_freq; exp_duty = pend_duty;
        exp_high = pend_high; exp_low = pend_low;
        pend_valid = 1'b0;
      end else begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_finish: got finish=1 expected 0");
      end
      check("busy_at_finish", busy, 0);
    end
    check("freq_track", freq, exp_freq);
    check("duty_track", duty, exp_duty);
    check("high_track", high_time, exp_high);
    check("low_track", low_time, exp_low);
  end

  task automatic expect_out(input string tag, input int f, input int d, input int h, input int l);
    check({tag, "_freq"}, freq, f);
    check({tag, "_duty"}, duty, d);
    check({tag, "_high"}, high_time, h);
    check({tag, "_low"}, low_time, l);
  endtask

  task automatic run_measure(input int h, input int l, input bit extra_en, input string tag);
    int fc0, lat;
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    model(h, l);
    fc0 = finish_count;
    enable = 1'b1;
    @(negedge clk); #1;
    enable = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    enable = extra_en;
    @(negedge clk);
    enable = 1'b0;
    repeat (l - 1) @(negedge clk);
    sig_in = 1'b1;
    lat = 0;
    while (finish_count == fc0 && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
    check({tag, "_latency_ok"}, (lat <= LAT_MAX), 1);
    repeat (20) @(negedge clk);
    #1;
    check({tag, "_finish_once"}, finish_count - fc0, 1);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic run_timeout(input bit stuck_high, input string tag);
    int fc0, lat, lo, hi;
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    pend_freq = 0; pend_duty = 0; pend_high = 0; pend_low = 0;
    pend_valid = 1'b1;
    fc0 = finish_count;
    enable = 1'b1;
    lat = 0;
    while (finish_count == fc0 && lat < T_OUT + 100) begin
      @(negedge clk); #1;
      lat++;
      if (lat == 1) enable = 1'b0;
      if (stuck_high && lat == 3) sig_in = 1'b1;
    end
    lo = stuck_high ? T_OUT + 6 : T_OUT + 1;
    hi = stuck_high ? T_OUT + 8 : T_OUT + 3;
    check({tag, "_finish_seen"}, finish_count - fc0, 1);
    check({tag, "_lat_window"}, (lat >= lo) && (lat <= hi), 1);
    check({tag, "_busy_low"}, busy, 0);
    expect_out(tag, 0, 0, 0, 0);
    sig_in = 1'b0;
  endtask

  initial begin
    int fc0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    expect_out("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_measure(40, 60, 1'b0, "m40_60");
    expect_out("m40_60", 500000, 40, 40, 60);
    run_measure(25, 25, 1'b1, "m25_25_busy_en");
    expect_out("m25_25", 1000000, 50, 25, 25);
    run_measure(1, 2, 1'b0, "m1_2");
    expect_out("m1_2", 16666666, 33, 1, 2);
    run_timeout(1'b0, "to_low");
    run_measure(40, 60, 1'b0, "m40_60b");
    expect_out("m40_60b", 500000, 40, 40, 60);
    run_timeout(1'b1, "to_high");
    run_measure(25, 25, 1'b0, "m25_25b");

    // Abort in the low phase; outputs were non-zero before the reset.
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    fc0 = finish_count;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    repeat (40) @(negedge clk);
    sig_in = 1'b0;
    repeat (20) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_finish", finish, 0);
    expect_out("abort", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (30) @(negedge clk);
      sig_in = ~sig_in;
    end
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_finish", finish_count - fc0, 0);
    check("abort_idle_busy", busy, 0);

    run_measure(30, 70, 1'b0, "m30_70");
    expect_out("m30_70", 500000, 30, 30, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/signal_measure_ctrl.md
SIGNAL_MEASURE_CTRL -- requirements
Module: signal_measure_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz, used as the frequency-division dividend.
REQ-002 clk  input  1  single system clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  start request; one-cycle pulse, sampled high in IDLE.
REQ-005 sig_in  input  1  measured signal, asynchronous to clk.
REQ-006 busy  output  1  high while a measurement is in progress.
REQ-007 finish  output  1  one-cycle pulse when results are updated.
REQ-008 freq  output  26  measured frequency in Hz.
REQ-009 duty  output  8  high-time percentage, 0..100, truncated.
REQ-010 high_time  output  20  high phase length in clk cycles.
REQ-011 low_time  output  20  low phase length in clk cycles.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer plus one history flop; rise/fall SHALL be detected on synchronized samples only.
REQ-013 FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, CALC_FREQ, CALC_DUTY, DONE.
REQ-014 IDLE->WAIT_RISE when enable=1; busy SHALL rise the next cycle; enable outside IDLE SHALL be ignored.
REQ-015 WAIT_RISE->MEAS_HIGH on the first detected rise; the high counter SHALL start at 1 on that cycle.
REQ-016 MEAS_HIGH SHALL increment the high counter each cycle; on fall go to MEAS_LOW with low counter=1.
REQ-017 MEAS_LOW SHALL increment the low counter each cycle; on the next rise go to CALC_FREQ; period = high+low (21-bit).
REQ-018 CALC_FREQ SHALL compute CLK_FREQ / period (truncating) via a sequential divider, one quotient bit per cycle.
REQ-019 CALC_DUTY SHALL compute (high*100) / period (truncating) with the same divider.
REQ-020 DONE SHALL load freq, duty, high_time, low_time together, pulse finish for exactly one cycle, drop busy in the same cycle, and return to IDLE.
REQ-021 Outputs SHALL hold their last values until the next DONE or reset.
REQ-022 Timeout: if any of WAIT_RISE, MEAS_HIGH, MEAS_LOW lasts 2^20-1 cycles, the FSM SHALL go to DONE with freq=0, duty=0, high_time=0, low_time=0 (constant or absent input).
REQ-023 Quotients wider than the output SHALL saturate at the output maximum; duty SHALL never exceed 100.
REQ-024 Latency from the completing rise to finish SHALL be at most 2x divider width + 4 cycles.
REQ-025 Resolution is one clk period; for CLK_FREQ=50 MHz, a 100-cycle period yields exactly 500000 Hz.

Reset
REQ-026 rst_n low SHALL asynchronously force FSM=IDLE, all counters, the divider and the synchronizer to 0, busy=0, finish=0, freq=0, duty=0, high_time=0, low_time=0.
REQ-027 Reset mid-measurement SHALL abort without producing finish; after release the block SHALL wait for a new enable.

Structure
REQ-028 Package signal_measure_pkg SHALL hold the FSM state type and constants CNT_W=20, FREQ_W=26, DUTY_W=8, TIMEOUT=2^20-1, DIV_W=32.
REQ-029 One sub-module, seq_divider (start/done, DIV_W-bit unsigned restoring divider, quotient and remainder), SHALL be instantiated once and time-shared by both calculations.

Verification
REQ-030 CLK_FREQ=50e6, sig_in period 2000 ns with 40% duty, enable pulse -> finish once; freq=500000, duty=40, high_time=40, low_time=60.
REQ-031 Same bench, then period 1000 ns with 50% duty, new enable -> freq=1000000, duty=50, high_time=25, low_time=25.
REQ-032 sig_in held at 0, enable -> finish after about 2^20 cycles with all outputs 0, busy low after finish.
REQ-033 enable pulsed again while busy -> ignored; exactly one finish pulse.
REQ-034 rst_n asserted during MEAS_LOW -> busy=0 immediately, outputs 0, no finish; next enable measures correctly.
REQ-035 Period 3 cycles (1 high, 2 low) -> freq=16666666, duty=33, high_time=1, low_time=2.
